// File: rtl/l2_bank_rr_arbiter.sv
// Round-robin arbiter sharing one L2 TCDM slave port among NR_MASTERS requesters, with in-order response routing.
// Optional conflict counter enabled by defining L2_ARB_CONFLICT_CNT_EN.
module l2_bank_rr_arbiter #(
  parameter int NR_MASTERS      = 5,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BE_WIDTH        = DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NR_MASTERS-1:0]            m_req_i,
  input  logic [NR_MASTERS*ADDR_WIDTH-1:0] m_add_i,
  input  logic [NR_MASTERS-1:0]            m_wen_i,
  input  logic [NR_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
  input  logic [NR_MASTERS*BE_WIDTH-1:0]   m_be_i,
  output logic [NR_MASTERS-1:0]            m_gnt_o,
  output logic [NR_MASTERS-1:0]            m_r_valid_o,
  output logic [DATA_WIDTH-1:0]            m_r_rdata_o,
  output logic                             m_r_opc_o,
  output logic                             s_req_o,
  output logic [ADDR_WIDTH-1:0]            s_add_o,
  output logic                             s_wen_o,
  output logic [DATA_WIDTH-1:0]            s_wdata_o,
  output logic [BE_WIDTH-1:0]              s_be_o,
  input  logic                             s_gnt_i,
  input  logic                             s_r_valid_i,
  input  logic [DATA_WIDTH-1:0]            s_r_rdata_i,
  input  logic                             s_r_opc_i,
  input  logic                             conflict_clr_i,
  output logic [31:0]                      conflict_cnt_o
);

  localparam int IDX_WIDTH = $clog2(NR_MASTERS);
  localparam int PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

  logic [IDX_WIDTH-1:0] r_ptr;
  logic [IDX_WIDTH-1:0] r_fifo [MAX_OUTSTANDING];
  logic [PTR_WIDTH-1:0] r_wr_ptr;
  logic [PTR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_WIDTH-1:0] r_count;

  logic [IDX_WIDTH-1:0] w_win;
  logic [IDX_WIDTH-1:0] w_head;
  logic                 w_any;
  logic                 w_can_accept;
  logic                 w_push;
  logic                 w_pop;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  // Scan requesters starting at the round-robin pointer; master 0 is the idle default.
  always_comb begin
    int idx;
    idx   = 0;
    w_win = '0;
    w_any = 1'b0;
    for (int k = 0; k < NR_MASTERS; k++) begin
      idx = (int'(r_ptr) + k) % NR_MASTERS;
      if (!w_any && m_req_i[idx]) begin
        w_any = 1'b1;
        w_win = IDX_WIDTH'(idx);
      end
    end
  end

  // TCDM handshake: a request transfers in the cycle s_req_o && s_gnt_i, and the
  // winning master sees its grant in that same cycle; responses carry no ready.
  assign w_can_accept = (r_count < CNT_WIDTH'(MAX_OUTSTANDING)) || s_r_valid_i;
  assign s_req_o      = rst_ni && w_any && w_can_accept;
  assign w_push       = s_req_o && s_gnt_i;
  assign w_pop        = rst_ni && s_r_valid_i && (r_count != '0);
  assign w_head       = r_fifo[r_rd_ptr];

  assign s_add_o   = m_add_i[w_win*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_wen_o   = m_wen_i[w_win];
  assign s_wdata_o = m_wdata_i[w_win*DATA_WIDTH +: DATA_WIDTH];
  assign s_be_o    = m_be_i[w_win*BE_WIDTH +: BE_WIDTH];

  assign m_r_rdata_o = s_r_rdata_i;
  assign m_r_opc_o   = s_r_opc_i;

  always_comb begin
    m_gnt_o     = '0;
    m_r_valid_o = '0;
    if (w_push) m_gnt_o[w_win] = 1'b1;
    if (w_pop)  m_r_valid_o[w_head] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_fifo[i] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_win;
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
        r_ptr            <= (w_win == IDX_WIDTH'(NR_MASTERS - 1)) ? '0 : w_win + IDX_WIDTH'(1);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_WIDTH'(1);
        2'b01:   r_count <= r_count - CNT_WIDTH'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding has no owner and is dropped.
  a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(s_r_valid_i && (r_count == '0)))
    else $warning("l2_bank_rr_arbiter: response received with empty routing FIFO, dropped");
`endif

`ifdef L2_ARB_CONFLICT_CNT_EN
  logic [31:0] r_conflict_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_conflict_cnt <= '0;
    end else if (conflict_clr_i) begin
      r_conflict_cnt <= '0;
    end else if (($countones(m_req_i) >= 2) && (r_conflict_cnt != '1)) begin
      r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign conflict_cnt_o = r_conflict_cnt;
`else
  logic w_unused_clr;
  assign w_unused_clr   = conflict_clr_i;
  assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_l2_bank_rr_arbiter.sv
// Bench for l2_bank_rr_arbiter: directed vector table, reset/counter sequences, and random traffic vs a queue model.
module tb_l2_bank_rr_arbiter;

  localparam int NM = 5;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int MO = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NM-1:0]     m_req = '0;
  logic [NM*AW-1:0]  m_add = '0;
  logic [NM-1:0]     m_wen = '0;
  logic [NM*DW-1:0]  m_wdata = '0;
  logic [NM*BW-1:0]  m_be = '0;
  logic [NM-1:0]     m_gnt;
  logic [NM-1:0]     m_r_valid;
  logic [DW-1:0]     m_r_rdata;
  logic              m_r_opc;
  logic              s_req;
  logic [AW-1:0]     s_add;
  logic              s_wen;
  logic [DW-1:0]     s_wdata;
  logic [BW-1:0]     s_be;
  logic              s_gnt = 1'b0;
  logic              s_r_valid = 1'b0;
  logic [DW-1:0]     s_r_rdata = '0;
  logic              s_r_opc = 1'b0;
  logic              conflict_clr = 1'b0;
  logic [31:0]       conflict_cnt;

  int errors = 0;
  int checks = 0;

  l2_bank_rr_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_req_i(m_req), .m_add_i(m_add), .m_wen_i(m_wen), .m_wdata_i(m_wdata), .m_be_i(m_be),
    .m_gnt_o(m_gnt), .m_r_valid_o(m_r_valid), .m_r_rdata_o(m_r_rdata), .m_r_opc_o(m_r_opc),
    .s_req_o(s_req), .s_add_o(s_add), .s_wen_o(s_wen), .s_wdata_o(s_wdata), .s_be_o(s_be),
    .s_gnt_i(s_gnt), .s_r_valid_i(s_r_valid), .s_r_rdata_i(s_r_rdata), .s_r_opc_i(s_r_opc),
    .conflict_clr_i(conflict_clr), .conflict_cnt_o(conflict_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m_req = '0; s_gnt = 1'b0; s_r_valid = 1'b0; s_r_opc = 1'b0; conflict_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic int onehot_idx(input logic [NM-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < NM; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [31:0] exp_conflict(input logic [31:0] model_cnt);
`ifdef L2_ARB_CONFLICT_CNT_EN
    return model_cnt;
`else
    return (model_cnt == 32'hFFFF_FFFF) ? 32'd1 : 32'd0;
`endif
  endfunction

  // vector table
  typedef struct {
    logic          rst;
    logic [NM-1:0] req;
    logic          gnt;
    logic          rv;
    logic [NM-1:0] exp_gnt;
    logic [NM-1:0] exp_rv;
    logic          exp_sreq;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rst, input logic [NM-1:0] req, input logic gnt, input logic rv,
                         input logic [NM-1:0] exp_gnt, input logic [NM-1:0] exp_rv, input logic exp_sreq);
    vec_t v;
    v.rst = rst; v.req = req; v.gnt = gnt; v.rv = rv;
    v.exp_gnt = exp_gnt; v.exp_rv = exp_rv; v.exp_sreq = exp_sreq;
    vecs.push_back(v);
  endtask

  // reference model state
  int          mdl_ptr;
  int          mdl_q[$];
  logic [31:0] mdl_cnt;

  task automatic random_cycle();
    int w, popc;
    bit found, can, sreq;
    logic [NM-1:0] egnt, erv;
    @(posedge clk); #1;
    for (int i = 0; i < NM; i++) begin
      m_add[i*AW +: AW]   = $urandom;
      m_wdata[i*DW +: DW] = $urandom;
      m_be[i*BW +: BW]    = BW'($urandom_range(0, 15));
    end
    m_wen        = NM'($urandom_range(0, 31));
    m_req        = ($urandom_range(0, 3) == 0) ? '0 : NM'($urandom_range(0, 31));
    s_gnt        = ($urandom_range(0, 3) != 0);
    s_r_valid    = (mdl_q.size() > 0) && ($urandom_range(0, 2) != 0);
    s_r_rdata    = $urandom;
    s_r_opc      = ($urandom_range(0, 7) == 0);
    conflict_clr = ($urandom_range(0, 15) == 0);
    @(negedge clk);
    found = 0; w = 0; popc = 0;
    for (int k = 0; k < NM; k++) begin
      int idx;
      idx = (mdl_ptr + k) % NM;
      if (!found && m_req[idx]) begin found = 1; w = idx; end
      if (m_req[k]) popc++;
    end
    can  = (mdl_q.size() < MO) || s_r_valid;
    sreq = found && can;
    egnt = (sreq && s_gnt) ? NM'(1 << w) : '0;
    erv  = (s_r_valid && mdl_q.size() > 0) ? NM'(1 << mdl_q[0]) : '0;
    chk("rnd_gnt", 32'(m_gnt), 32'(egnt));
    chk("rnd_rvalid", 32'(m_r_valid), 32'(erv));
    chk("rnd_sreq", 32'(s_req), 32'(sreq));
    chk("rnd_rdata", m_r_rdata, s_r_rdata);
    chk("rnd_opc", 32'(m_r_opc), 32'(s_r_opc));
    chk("rnd_conflict", conflict_cnt, exp_conflict(mdl_cnt));
    if (found) begin
      chk("rnd_add", s_add, m_add[w*AW +: AW]);
      chk("rnd_wen", 32'(s_wen), 32'(m_wen[w]));
      chk("rnd_wdata", s_wdata, m_wdata[w*DW +: DW]);
      chk("rnd_be", 32'(s_be), 32'(m_be[w*BW +: BW]));
    end
    if (s_r_valid && mdl_q.size() > 0) void'(mdl_q.pop_front());
    if (sreq && s_gnt) begin
      mdl_q.push_back(w);
      mdl_ptr = (w + 1) % NM;
    end
    if (conflict_clr) mdl_cnt = 0;
    else if (popc >= 2 && mdl_cnt != 32'hFFFF_FFFF) mdl_cnt = mdl_cnt + 1;
  endtask

  initial begin
    for (int i = 0; i < NM; i++) begin
      m_add[i*AW +: AW]   = 32'h1C00_0000 + 32'(i * 8);
      m_wdata[i*DW +: DW] = 32'hA000_0000 + 32'(i);
      m_be[i*BW +: BW]    = 4'hF;
    end
    m_wen = 5'b10101;

    // reset state
    #2;
    chk("rst_gnt", 32'(m_gnt), 32'd0);
    chk("rst_rvalid", 32'(m_r_valid), 32'd0);
    chk("rst_sreq", 32'(s_req), 32'd0);
    chk("rst_conflict", conflict_cnt, 32'd0);

    // single read from master 2
    add_vec(1, 5'b00100, 1, 0, 5'b00100, 5'b00000, 1);
    add_vec(0, 5'b00000, 1, 1, 5'b00000, 5'b00100, 0);
    // all masters, back-to-back 1-cycle responses
    add_vec(1, 5'b11111, 1, 0, 5'b00001, 5'b00000, 1);
    add_vec(0, 5'b11111, 1, 1, 5'b00010, 5'b00001, 1);
    add_vec(0, 5'b11111, 1, 1, 5'b00100, 5'b00010, 1);
    add_vec(0, 5'b11111, 1, 1, 5'b01000, 5'b00100, 1);
    add_vec(0, 5'b11111, 1, 1, 5'b10000, 5'b01000, 1);
    add_vec(0, 5'b11111, 1, 1, 5'b00001, 5'b10000, 1);
    add_vec(0, 5'b00000, 1, 1, 5'b00000, 5'b00001, 0);
    // slow slave, masters 0 and 3: fill, stall, then grant on the pop cycle
    add_vec(1, 5'b01001, 1, 0, 5'b00001, 5'b00000, 1);
    add_vec(0, 5'b01001, 1, 0, 5'b01000, 5'b00000, 1);
    add_vec(0, 5'b01001, 1, 0, 5'b00000, 5'b00000, 0);
    add_vec(0, 5'b01001, 1, 0, 5'b00000, 5'b00000, 0);
    add_vec(0, 5'b01001, 1, 1, 5'b00001, 5'b00001, 1);
    add_vec(0, 5'b00000, 1, 1, 5'b00000, 5'b01000, 0);
    add_vec(0, 5'b00000, 1, 1, 5'b00000, 5'b00001, 0);
    // pointer wrap 4 -> 0, then a slave that withholds grant
    add_vec(1, 5'b01000, 1, 0, 5'b01000, 5'b00000, 1);
    add_vec(0, 5'b10001, 1, 1, 5'b10000, 5'b01000, 1);
    add_vec(0, 5'b10001, 1, 1, 5'b00001, 5'b10000, 1);
    add_vec(0, 5'b00000, 1, 1, 5'b00000, 5'b00001, 0);
    add_vec(0, 5'b00010, 0, 0, 5'b00000, 5'b00000, 1);
    add_vec(0, 5'b00010, 1, 0, 5'b00010, 5'b00000, 1);
    add_vec(0, 5'b00000, 1, 1, 5'b00000, 5'b00010, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      @(posedge clk); #1;
      m_req     = vecs[i].req;
      s_gnt     = vecs[i].gnt;
      s_r_valid = vecs[i].rv;
      s_r_rdata = 32'hDEAD_BEEF ^ 32'(i);
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", i), 32'(m_gnt), 32'(vecs[i].exp_gnt));
      chk($sformatf("vec%0d_rvalid", i), 32'(m_r_valid), 32'(vecs[i].exp_rv));
      chk($sformatf("vec%0d_sreq", i), 32'(s_req), 32'(vecs[i].exp_sreq));
      chk($sformatf("vec%0d_rdata", i), m_r_rdata, 32'hDEAD_BEEF ^ 32'(i));
      if (vecs[i].exp_gnt != '0) begin
        chk($sformatf("vec%0d_add", i), s_add, 32'h1C00_0000 + 32'(onehot_idx(vecs[i].exp_gnt) * 8));
        chk($sformatf("vec%0d_wen", i), 32'(s_wen), 32'(m_wen[onehot_idx(vecs[i].exp_gnt)]));
      end
    end
    @(posedge clk); #1; idle_inputs();

    // reset with two entries outstanding
    do_reset();
    @(posedge clk); #1; m_req = 5'b00011; s_gnt = 1'b1;
    @(negedge clk); chk("rmid_gnt0", 32'(m_gnt), 32'b00001);
    @(posedge clk); #1;
    @(negedge clk); chk("rmid_gnt1", 32'(m_gnt), 32'b00010);
    @(posedge clk); #1; s_r_valid = 1'b1; rst_n = 1'b0; #1;
    chk("rmid_async_gnt", 32'(m_gnt), 32'd0);
    chk("rmid_async_sreq", 32'(s_req), 32'd0);
    chk("rmid_async_rvalid", 32'(m_r_valid), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; m_req = '0; s_gnt = 1'b0; s_r_valid = 1'b1;
    @(negedge clk);
    chk("rmid_drop_rvalid", 32'(m_r_valid), 32'd0);
    chk("rmid_conflict", conflict_cnt, 32'd0);
    @(posedge clk); #1; m_req = 5'b11111; s_gnt = 1'b1; s_r_valid = 1'b0;
    @(negedge clk); chk("rmid_ptr0_gnt", 32'(m_gnt), 32'b00001);
    @(posedge clk); #1; m_req = '0; s_r_valid = 1'b1;
    @(negedge clk); chk("rmid_rsp", 32'(m_r_valid), 32'b00001);
    @(posedge clk); #1; idle_inputs();

    // conflict counter: three conflict cycles, one single-request cycle, then clear vs increment
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1; m_req = (c < 3) ? 5'b00011 : 5'b00001;
    end
    @(posedge clk); #1; m_req = '0;
    @(negedge clk);
`ifdef L2_ARB_CONFLICT_CNT_EN
    chk("cnt_three", conflict_cnt, 32'd3);
`else
    chk("cnt_three", conflict_cnt, 32'd0);
`endif
    @(posedge clk); #1; m_req = 5'b00011; conflict_clr = 1'b1;
    @(posedge clk); #1; m_req = '0; conflict_clr = 1'b0;
    @(negedge clk); chk("cnt_cleared", conflict_cnt, 32'd0);

    // random traffic against the queue model
    do_reset();
    mdl_ptr = 0;
    mdl_q.delete();
    mdl_cnt = 0;
    for (int n = 0; n < 400; n++) random_cycle();
    @(posedge clk); #1; idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
